output_layer_mac: RTL and testbench
===================================

# output_layer_mac

- Computes the ten ELM output-layer scores for one image.
- Consumes a stream of `num_hidden` hidden-neuron activations, each paired with that neuron's ten output weights, and runs ten parallel signed multiply-accumulate lanes.
- Presents the ten saturated scores as a registered, held bus, with a one-cycle `result_valid` pulse.
- Sits directly upstream of the argmax/classification stage: `out0..out9` feed its score inputs, and `result_valid` is its load strobe.

## Interface
- `num_hidden`, 32: activations (beats) per frame; ≥2.
- `act_width`, 8: unsigned hidden-activation width.
- `weight_width`, 8: signed output-weight width.
- `bit_length`, 21: signed score width; matches the downstream classifier input width.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `clear` input 1: synchronous frame abort, active-high.
- `in_valid` input 1: activation beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `act_in` input `act_width`: unsigned activation h_j.
- `weight_in` input 10·`weight_width`: signed weights; lane k occupies bits [k·`weight_width` +: `weight_width`].
- `out0`..`out9` output `bit_length` each: signed class scores, held between frames.
- `result_valid` output 1: one-cycle pulse; `out0..out9` are new and valid in that same cycle.

## Operation
- **FSM states:**
  - ACCUM: `in_ready = !clear`.
  - DONE: `in_ready = 0`, `result_valid = 1`.
  - ACCUM → DONE when the beat with count = `num_hidden`−1 is accepted.
  - DONE → ACCUM unconditionally after one cycle.
- **Beat counter:** width clog2(`num_hidden`); increments per accepted beat; returns to 0 on the last beat.
- **Lane k product:** p_k = signed({1'b0, act_in}) × signed(w_k), width `act_width`+`weight_width`+1, sign-extended to `bit_length`+1.
- **Lane k accumulate:**
  - On the first beat (count = 0): acc_k ← p_k. No separate clear cycle is needed between frames.
  - Otherwise: acc_k ← sat(acc_k + p_k).
- **Saturation:** sat() clamps to [−2^(`bit_length`−1), 2^(`bit_length`−1)−1]. At the defaults no frame can saturate (maximum magnitude 1,044,480 < 2^20), but lanes must implement saturation for overridden parameters.
- **Output register:** `out_k` loads sat(acc_k + p_k) on the last accepted beat.
- **`clear`:**
  - Counter returns to 0, FSM goes to ACCUM, no beat is accepted that cycle (clear beats a simultaneous `in_valid`).
  - `out*` are held; `result_valid` is 0 in the following cycle.
  - `clear` during DONE does not suppress the pulse already asserted; the FSM still returns to ACCUM.
- **Gaps:** `in_valid` low mid-frame stalls the frame with no timeout; accumulators are held.
- **Reset values:**
  - `out0..out9` = 0, `result_valid` = 0.
  - FSM = ACCUM, counter = 0, accumulators = 0.
  - `in_ready` = 1 once `reset` is released, since it is combinational from state and `clear`.
- Reset asserted mid-frame discards the partial frame immediately (asynchronous).

## Timing
- **Latency:** the last beat accepted at edge N gives `out*` and `result_valid` = 1 during cycle N→N+1. `result_valid` drops at edge N+1.
- **Throughput:** `num_hidden`+1 cycles per frame at full rate; one bubble, the DONE cycle.
- **Scores:** `out*` change only at the last-beat edge. They are stable for at least `num_hidden` cycles afterwards, which exceeds the downstream classifier's 12-cycle scan.
- **Datapath:** one multiply plus add/saturate per lane per cycle; no internal pipelining.
- `in_ready` depends on state and `clear` only, never on `in_valid`.

## Structure
- **`elm_pkg`:**
  - `NUM_CLASSES = 10`.
  - Default widths: `bit_length`, `act_width`, `weight_width`.
  - Saturation limit constants.
  - FSM state enum {ACCUM, DONE}.
  - These are shared with the classifier and the hidden-layer stage.
- **Sub-module `mac_lane`:**
  - One signed multiply plus saturating accumulate with first-beat load.
  - Generated 10×.
- The top level owns the FSM, the beat counter and the output registers.

## Test plan
- **All ones:** 32 beats with act = 1 and all weights = 1 → `out0..out9` = 32. `result_valid` is high exactly one cycle, the cycle after the 32nd accepted beat; `in_ready` = 0 in that cycle.
- **Extremes:**
  - Lane 0 with act = 255, w = 127 ×32 → `out0` = 1,036,320.
  - Lane 1 with w = −128 → `out1` = −1,044,480.
  - Lane k with w = k, act = 1 → `out_k` = 32k.
- **Saturation:** `num_hidden` = 64, act = 255, w0 = 127, w1 = −128 → `out0` = 1,048,575, `out1` = −1,048,576.
- **Gaps and back-to-back:** random `in_valid` gaps mid-frame give the same scores as gap-free input. Two consecutive frames (ones, then act = 2) → 32 then 64, with no residue from frame one.
- **Clear:** `clear` after 10 beats with `in_valid` high → that beat is dropped, no pulse occurs, `out*` keep their previous frame values. The next 32 beats produce the correct fresh result.
- **Async reset:** `reset` low mid-frame, between clock edges → `out*` = 0 and `result_valid` = 0 immediately. After release, a full frame completes normally.

Source files
------------

// File: rtl/elm_pkg.sv
// Shared ELM constants: class count, default widths, saturation limits and the MAC FSM states.
package elm_pkg;

    localparam int unsigned NUM_CLASSES  = 10;
    localparam int unsigned NUM_HIDDEN   = 32;
    localparam int unsigned ACT_WIDTH    = 8;
    localparam int unsigned WEIGHT_WIDTH = 8;
    localparam int unsigned BIT_LENGTH   = 21;

    localparam logic signed [BIT_LENGTH-1:0] SAT_MAX = {1'b0, {(BIT_LENGTH-1){1'b1}}};
    localparam logic signed [BIT_LENGTH-1:0] SAT_MIN = {1'b1, {(BIT_LENGTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } mac_state_e;

endpackage

// File: rtl/mac_lane.sv
// One output-layer lane: unsigned activation times signed weight, saturating accumulate
// with a first-beat load so frames need no separate clear cycle.
module mac_lane #(
    parameter int unsigned act_width    = 8,
    parameter int unsigned weight_width = 8,
    parameter int unsigned bit_length   = 21
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic                         first,
    input  logic [act_width-1:0]         act,
    input  logic [weight_width-1:0]      weight,
    output logic signed [bit_length-1:0] sat_sum_c
);

    localparam int unsigned PROD_W = act_width + weight_width + 1;
    localparam int unsigned EXT_W  = bit_length + 1;
    localparam logic signed [EXT_W-1:0] MAX_EXT = $signed({2'b00, {(bit_length-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] MIN_EXT = $signed({2'b11, {(bit_length-1){1'b0}}});

    logic signed [PROD_W-1:0]     act_s;
    logic signed [PROD_W-1:0]     weight_s;
    logic signed [PROD_W-1:0]     prod;
    logic signed [EXT_W-1:0]      sum_ext;
    logic signed [bit_length-1:0] acc_q;

    assign act_s    = $signed(PROD_W'({1'b0, act}));
    assign weight_s = PROD_W'($signed(weight));
    assign prod     = act_s * weight_s;
    assign sum_ext  = EXT_W'(acc_q) + EXT_W'(prod);

    // Clamp the one-bit-wider sum back into the score range
    always_comb begin
        sat_sum_c = bit_length'(sum_ext);
        if (sum_ext > MAX_EXT) begin
            sat_sum_c = bit_length'(MAX_EXT);
        end else if (sum_ext < MIN_EXT) begin
            sat_sum_c = bit_length'(MIN_EXT);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (load_en) begin
            acc_q <= first ? bit_length'(prod) : sat_sum_c;
        end
    end

endmodule

// File: rtl/output_layer_mac.sv
// ELM output layer: ten parallel MAC lanes over a num_hidden-beat activation stream,
// publishing held saturated scores with a one-cycle result_valid pulse.
module output_layer_mac
    import elm_pkg::*;
#(
    parameter int unsigned num_hidden   = 32,
    parameter int unsigned act_width    = 8,
    parameter int unsigned weight_width = 8,
    parameter int unsigned bit_length   = 21
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [act_width-1:0]                  act_in,
    input  logic [NUM_CLASSES*weight_width-1:0]   weight_in,
    output logic signed [bit_length-1:0]          out0,
    output logic signed [bit_length-1:0]          out1,
    output logic signed [bit_length-1:0]          out2,
    output logic signed [bit_length-1:0]          out3,
    output logic signed [bit_length-1:0]          out4,
    output logic signed [bit_length-1:0]          out5,
    output logic signed [bit_length-1:0]          out6,
    output logic signed [bit_length-1:0]          out7,
    output logic signed [bit_length-1:0]          out8,
    output logic signed [bit_length-1:0]          out9,
    output logic                                  result_valid
);

    localparam int unsigned CNT_W = $clog2(num_hidden);

    mac_state_e                   state_q;
    mac_state_e                   state_d;
    logic [CNT_W-1:0]             count_q;
    logic                         accept;
    logic                         last_beat;
    logic signed [bit_length-1:0] lane_sum [NUM_CLASSES];
    logic signed [bit_length-1:0] out_q    [NUM_CLASSES];

    // Ready depends only on state and clear so upstream can never form a loop through it
    assign in_ready  = (state_q == ACCUM) && !clear;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (count_q == CNT_W'(num_hidden - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_beat) state_d = DONE;
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (clear) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= last_beat;
            if (clear) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= last_beat ? '0 : count_q + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        mac_lane #(
            .act_width    (act_width),
            .weight_width (weight_width),
            .bit_length   (bit_length)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .load_en   (accept),
            .first     (count_q == '0),
            .act       (act_in),
            .weight    (weight_in[k*weight_width +: weight_width]),
            .sat_sum_c (lane_sum[k])
        );

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                out_q[k] <= '0;
            end else if (last_beat) begin
                out_q[k] <= lane_sum[k];
            end
        end
    end

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
    assign out4 = out_q[4];
    assign out5 = out_q[5];
    assign out6 = out_q[6];
    assign out7 = out_q[7];
    assign out8 = out_q[8];
    assign out9 = out_q[9];

endmodule

// File: tb/tb_output_layer_mac.sv
// Self-checking bench for output_layer_mac: directed and randomized frames scored against
// a plain-arithmetic dot-product model, plus a 64-beat instance for saturation.
module tb_output_layer_mac;

    logic               clock = 1'b0;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic               sat_valid;
    logic               in_ready;
    logic               sat_ready;
    logic [7:0]         act_in;
    logic [79:0]        weight_in;
    logic               rv;
    logic               sat_rv;
    logic signed [20:0] o  [10];
    logic signed [20:0] so [10];

    int pass_cnt = 0;
    int total    = 0;

    int unsigned acts [64];
    int          wts  [64][10];
    longint      prev [10];

    always #5 clock = ~clock;

    output_layer_mac #(.num_hidden(32)) dut (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .act_in(act_in), .weight_in(weight_in),
        .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]), .out4(o[4]),
        .out5(o[5]), .out6(o[6]), .out7(o[7]), .out8(o[8]), .out9(o[9]),
        .result_valid(rv)
    );

    output_layer_mac #(.num_hidden(64)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(sat_valid), .in_ready(sat_ready),
        .act_in(act_in), .weight_in(weight_in),
        .out0(so[0]), .out1(so[1]), .out2(so[2]), .out3(so[3]), .out4(so[4]),
        .out5(so[5]), .out6(so[6]), .out7(so[7]), .out8(so[8]), .out9(so[9]),
        .result_valid(sat_rv)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference score: plain dot product over n beats, clamped to the 21-bit signed range
    function automatic longint model(input int n, input int k);
        longint s = 0;
        for (int j = 0; j < n; j++) s += longint'(acts[j]) * longint'(wts[j][k]);
        if (s > 1048575) s = 1048575;
        if (s < -1048576) s = -1048576;
        return s;
    endfunction

    function automatic longint score(input bit sel, input int k);
        return sel ? longint'(so[k]) : longint'(o[k]);
    endfunction

    task automatic fill_const(input int unsigned a, input int w_all);
        for (int j = 0; j < 64; j++) begin
            acts[j] = a;
            for (int k = 0; k < 10; k++) wts[j][k] = w_all;
        end
    endtask

    task automatic fill_rand();
        for (int j = 0; j < 64; j++) begin
            acts[j] = $urandom_range(255);
            for (int k = 0; k < 10; k++) wts[j][k] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic drive_beat(input int j, input bit sel);
        @(negedge clock);
        act_in = 8'(acts[j]);
        for (int k = 0; k < 10; k++) weight_in[k*8 +: 8] = 8'(wts[j][k]);
        if (sel) sat_valid = 1'b1; else in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid  = 1'b0;
        sat_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit sel, input int gap_pct, input string tag);
        for (int j = 0; j < n; j++) begin
            while (j > 0 && int'($urandom_range(99)) < gap_pct) idle();
            drive_beat(j, sel);
            if (j == 0) chk({tag, "_ready_first"}, longint'(sel ? sat_ready : in_ready), 1);
            if (j == n - 1) chk({tag, "_rv_before_last"}, longint'(sel ? sat_rv : rv), 0);
            @(posedge clock);
        end
        idle();
        chk({tag, "_rv_pulse"}, longint'(sel ? sat_rv : rv), 1);
        chk({tag, "_ready_done"}, longint'(sel ? sat_ready : in_ready), 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_out%0d", tag, k), score(sel, k), model(n, k));
            if (!sel) prev[k] = model(n, k);
        end
        idle();
        chk({tag, "_rv_drop"}, longint'(sel ? sat_rv : rv), 0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; sat_valid = 1'b0;
        act_in = '0; weight_in = '0;
        #3;
        chk("reset_rv", longint'(rv), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("reset_out%0d", k), longint'(o[k]), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        #1 chk("ready_after_reset", longint'(in_ready), 1);

        fill_const(1, 1);
        run_frame(32, 1'b0, 0, "ones");
        chk("ones_const_out5", longint'(o[5]), 32);

        fill_rand();
        for (int j = 0; j < 32; j++) begin
            acts[j] = 255; wts[j][0] = 127; wts[j][1] = -128;
        end
        run_frame(32, 1'b0, 0, "extreme");
        chk("extreme_const_out0", longint'(o[0]), 1036320);
        chk("extreme_const_out1", longint'(o[1]), -1044480);

        for (int j = 0; j < 64; j++) begin
            acts[j] = 1;
            for (int k = 0; k < 10; k++) wts[j][k] = k;
        end
        run_frame(32, 1'b0, 0, "lane_k");
        chk("lane_k_const_out9", longint'(o[9]), 288);

        fill_const(255, 0);
        for (int j = 0; j < 64; j++) begin wts[j][0] = 127; wts[j][1] = -128; end
        run_frame(64, 1'b1, 0, "sat");
        chk("sat_const_out0", longint'(so[0]), 1048575);
        chk("sat_const_out1", longint'(so[1]), -1048576);

        fill_rand();
        run_frame(32, 1'b0, 35, "gaps");
        run_frame(32, 1'b0, 0, "nogaps");

        fill_const(1, 1);
        run_frame(32, 1'b0, 0, "b2b_a");
        fill_const(2, 1);
        run_frame(32, 1'b0, 0, "b2b_b");
        chk("b2b_const_out3", longint'(o[3]), 64);

        // Abort a frame after 10 beats with a beat offered in the clear cycle
        fill_rand();
        for (int j = 0; j < 10; j++) begin drive_beat(j, 1'b0); @(posedge clock); end
        drive_beat(10, 1'b0);
        clear = 1'b1;
        #1 chk("clear_ready", longint'(in_ready), 0);
        @(posedge clock);
        idle();
        clear = 1'b0;
        chk("clear_no_pulse", longint'(rv), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("clear_hold_out%0d", k), score(1'b0, k), prev[k]);
        idle();
        chk("clear_no_pulse_late", longint'(rv), 0);
        fill_rand();
        run_frame(32, 1'b0, 10, "after_clear");

        // Asynchronous reset between edges, mid-frame
        fill_rand();
        for (int j = 0; j < 15; j++) begin drive_beat(j, 1'b0); @(posedge clock); end
        #3 reset = 1'b0;
        #1;
        chk("async_rv", longint'(rv), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("async_out%0d", k), longint'(o[k]), 0);
        idle();
        @(negedge clock);
        reset = 1'b1;
        fill_rand();
        run_frame(32, 1'b0, 0, "after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
